// File: rtl/sd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : sd_pkg                                                        |
// | Description: Shared helpers for the sigma-delta magnitude path: clog2,     |
// |              full-scale computation and bit-decode constants.              |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package sd_pkg;

  // Bit values as they appear on the sigma-delta line.
  localparam logic SD_BIT_POS = 1'b1;
  localparam logic SD_BIT_NEG = 1'b0;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Full scale for a given output width: 2^(width-1)-1.
  function automatic int sd_fs(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  // Decoded level of one bitstream bit: +FS for a one, -FS for a zero.
  function automatic int sd_decode(input logic bit_in, input int width);
    return (bit_in == SD_BIT_POS) ? sd_fs(width) : -sd_fs(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_leaky_int.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : sd_leaky_int                                                  |
// | Description: First-order leaky integrator, acc <= acc + din - (acc>>GAIN), |
// |              dout = acc >> GAIN. SIGNED selects arithmetic vs logical      |
// |              shift and sign vs zero extension of the operands.             |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module sd_leaky_int #(
  parameter int DATA_WIDTH = 17,
  parameter int GAIN       = 6,
  parameter bit SIGNED     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int c_ACC_W = DATA_WIDTH + GAIN;

  logic [c_ACC_W-1:0]    r_acc;
  logic [DATA_WIDTH-1:0] w_leak;
  logic [c_ACC_W-1:0]    w_din_ext;
  logic [c_ACC_W-1:0]    w_leak_ext;

  // The leak always fits DATA_WIDTH bits, so truncating the shifted
  // accumulator only drops redundant sign/zero bits.
  if (SIGNED) begin : g_signed
    assign w_leak     = DATA_WIDTH'($signed(r_acc) >>> GAIN);
    assign w_din_ext  = {{GAIN{din[DATA_WIDTH-1]}}, din};
    assign w_leak_ext = {{GAIN{w_leak[DATA_WIDTH-1]}}, w_leak};
  end else begin : g_unsigned
    assign w_leak     = DATA_WIDTH'(r_acc >> GAIN);
    assign w_din_ext  = {{GAIN{1'b0}}, din};
    assign w_leak_ext = {{GAIN{1'b0}}, w_leak};
  end

  assign dout = w_leak;

  // Accumulator update; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (en) begin
      r_acc <= r_acc + w_din_ext - w_leak_ext;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sd_magnitude.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : sd_magnitude                                                  |
// | Description: Magnitude envelope of a 1-bit sigma-delta stream. Decode to   |
// |              +/-FS, signed leaky-integrator demodulator, rectifier, then   |
// |              an optional unsigned leaky-integrator smoother.               |
// |              Build option: SD_MAGNITUDE_SMOOTH_EN enables the smoother;    |
// |              without it the rectified value is registered directly.       |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module sd_magnitude #(
  parameter int WIDTH = 16,
  parameter int GAIN  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in,
  output logic [WIDTH-1:0] out
);

  import sd_pkg::*;

  localparam logic [WIDTH:0] c_POS_FS = (WIDTH+1)'(sd_decode(SD_BIT_POS, WIDTH));
  localparam logic [WIDTH:0] c_NEG_FS = (WIDTH+1)'(sd_decode(SD_BIT_NEG, WIDTH));

  logic [WIDTH:0]   w_v;
  logic [WIDTH:0]   w_e1;
  logic [WIDTH-2:0] w_mag;
  logic [WIDTH-1:0] w_scaled;

  // Decode the incoming bit to a signed full-scale level.
  assign w_v = in ? c_POS_FS : c_NEG_FS;

  sd_leaky_int #(
    .DATA_WIDTH (WIDTH + 1),
    .GAIN       (GAIN),
    .SIGNED     (1'b1)
  ) u_stage1 (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  (w_v),
    .dout (w_e1)
  );

  // |e1| never exceeds FS, so it fits WIDTH-1 bits; doubling maps it onto
  // the full unsigned output range.
  assign w_mag    = (WIDTH-1)'(w_e1[WIDTH] ? (-w_e1) : w_e1);
  assign w_scaled = {w_mag, 1'b0};

`ifdef SD_MAGNITUDE_SMOOTH_EN
  logic [WIDTH-1:0] w_smooth;

  // The smoother's accumulator is the output register; out = a2 >> GAIN.
  sd_leaky_int #(
    .DATA_WIDTH (WIDTH),
    .GAIN       (GAIN),
    .SIGNED     (1'b0)
  ) u_stage2 (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  (w_scaled),
    .dout (w_smooth)
  );

  assign out = w_smooth;
`else
  logic [WIDTH-1:0] r_out;

  // Register the rectified demodulator output directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else if (en) begin
      r_out <= w_scaled;
    end
  end

  assign out = r_out;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sd_magnitude.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_sd_magnitude                                               |
// | Description: Self-checking bench for sd_magnitude with an arithmetic       |
// |              reference model and a first-order modulator for stimulus.     |
// |              Honours SD_MAGNITUDE_SMOOTH_EN the same way as the design.    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_sd_magnitude;

  localparam int     WIDTH = 16;
  localparam int     GAIN  = 6;
  localparam longint FS    = 32767;
  localparam longint DIV   = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             in;
  logic [WIDTH-1:0] out;

  int checks   = 0;
  int failures = 0;

  // Reference model state: integer accumulators of both stages.
  longint           m_a1;
  longint           m_a2;
  logic [WIDTH-1:0] m_out;
  longint           mod_acc;

  sd_magnitude #(
    .WIDTH (WIDTH),
    .GAIN  (GAIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .in  (in),
    .out (out)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic longint floor_div(input longint n, input longint d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  // Drive one clock with the given inputs and advance the reference model.
  task automatic step(input logic b, input logic e, input logic r);
    longint v;
    longint e1;
    longint s;
`ifdef SD_MAGNITUDE_SMOOTH_EN
    longint o;
`endif
    rst = r;
    en  = e;
    in  = b;
    @(posedge clk);
    if (r) begin
      m_a1  = 0;
      m_a2  = 0;
      m_out = '0;
    end else if (e) begin
      v  = b ? FS : -FS;
      e1 = floor_div(m_a1, DIV);
      s  = 2 * ((e1 < 0) ? -e1 : e1);
`ifdef SD_MAGNITUDE_SMOOTH_EN
      o     = m_a2 / DIV;
      m_a2  = m_a2 + s - o;
      m_out = WIDTH'(m_a2 / DIV);
`else
      m_out = WIDTH'(s);
`endif
      m_a1 = m_a1 + v - e1;
    end
    #1;
  endtask

  // First-order sigma-delta modulator for a signed 8-bit input.
  task automatic mod_bit(input int x, output logic b);
    b       = (mod_acc >= 0);
    mod_acc = mod_acc + x - (b ? 128 : -128);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step(i[0], 1'b1, 1'b1);
      checks++;
      if (out !== 16'd0) begin
        failures++;
        $display("FAIL reset_hold cycle %0d got %0d expected 0", i, out);
      end
    end
    step($urandom_range(0, 1) == 1, 1'b1, 1'b0);
    checks++;
    if (out !== 16'd0 || m_out !== 16'd0) begin
      failures++;
      $display("FAIL reset_release got %0d expected 0 (model %0d)", out, m_out);
    end
  endtask

  task automatic test_constant(input logic b, input string name);
    int bad;
    logic [WIDTH-1:0] bad_got;
    logic [WIDTH-1:0] bad_exp;
    bad = -1;
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      step(b, 1'b1, 1'b0);
      if (out !== m_out && bad < 0) begin
        bad = i; bad_got = out; bad_exp = m_out;
      end
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s_traj cycle %0d got %0d expected %0d", name, bad, bad_got, bad_exp);
    end
    checks++;
    if (out < 16'd65000 || out > 16'd65534) begin
      failures++;
      $display("FAIL %s_range got %0d expected 65000..65534", name, out);
    end
  endtask

  task automatic test_idle;
    int bad;
    logic [WIDTH-1:0] bad_got;
    logic [WIDTH-1:0] bad_exp;
    logic [WIDTH-1:0] peak;
    bad  = -1;
    peak = '0;
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      step(i[0] == 1'b0, 1'b1, 1'b0);
      if (out !== m_out && bad < 0) begin
        bad = i; bad_got = out; bad_exp = m_out;
      end
      if (i >= 1000 && out > peak) peak = out;
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL idle_traj cycle %0d got %0d expected %0d", bad, bad_got, bad_exp);
    end
    checks++;
    if (peak >= 16'd4096) begin
      failures++;
      $display("FAIL idle_ripple peak %0d expected below 4096", peak);
    end
  endtask

  task automatic test_modulator(input int x, input string name);
    int bad;
    logic [WIDTH-1:0] bad_got;
    logic [WIDTH-1:0] bad_exp;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic b;
    bad     = -1;
    lo      = '1;
    hi      = '0;
    mod_acc = longint'($urandom_range(0, 255)) - 128;
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      mod_bit(x, b);
      step(b, 1'b1, 1'b0);
      if (out !== m_out && bad < 0) begin
        bad = i; bad_got = out; bad_exp = m_out;
      end
      if (i >= 1700) begin
        if (out < lo) lo = out;
        if (out > hi) hi = out;
      end
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s_traj cycle %0d got %0d expected %0d", name, bad, bad_got, bad_exp);
    end
    if (x == 0) begin
      checks++;
      if (hi >= 16'd4096) begin
        failures++;
        $display("FAIL %s_level peak %0d expected below 4096", name, hi);
      end
    end else begin
      checks++;
      if (lo < 16'd30719 || hi > 16'd34815) begin
        failures++;
        $display("FAIL %s_level range %0d..%0d expected within 30719..34815", name, lo, hi);
      end
    end
  endtask

  task automatic test_en_hold;
    int bad;
    int moved;
    logic [WIDTH-1:0] bad_got;
    logic [WIDTH-1:0] bad_exp;
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] moved_val;
    bad   = -1;
    moved = -1;
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) step($urandom_range(0, 3) != 0, 1'b1, 1'b0);
    held = out;
    for (int i = 0; i < 100; i++) begin
      step($urandom_range(0, 1) == 1, 1'b0, 1'b0);
      if (out !== held && moved < 0) begin
        moved = i; moved_val = out;
      end
    end
    checks++;
    if (moved >= 0) begin
      failures++;
      $display("FAIL en_hold cycle %0d got %0d expected %0d", moved, moved_val, held);
    end
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 1) == 1, 1'b1, 1'b0);
      if (out !== m_out && bad < 0) begin
        bad = i; bad_got = out; bad_exp = m_out;
      end
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL en_resume cycle %0d got %0d expected %0d", bad, bad_got, bad_exp);
    end
  endtask

  task automatic test_reset_mid;
    logic [WIDTH-1:0] fresh [400];
    int bad;
    int diff;
    int n;
    logic [WIDTH-1:0] bad_got;
    logic [WIDTH-1:0] bad_exp;
    bad  = -1;
    diff = -1;
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 400; i++) begin
      step(1'b1, 1'b1, 1'b0);
      fresh[i] = out;
      if (out !== m_out && bad < 0) begin
        bad = i; bad_got = out; bad_exp = m_out;
      end
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL fresh_traj cycle %0d got %0d expected %0d", bad, bad_got, bad_exp);
    end
    step(1'b0, 1'b1, 1'b1);
    n = 0;
    while (out < 16'd30000 && n < 1000) begin
      step(1'b1, 1'b1, 1'b0);
      n++;
    end
    checks++;
    if (out < 16'd30000) begin
      failures++;
      $display("FAIL settle_timeout got %0d expected at least 30000", out);
    end
    step(1'b1, 1'b1, 1'b1);
    checks++;
    if (out !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset got %0d expected 0", out);
    end
    for (int i = 0; i < 400; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (out !== fresh[i] && diff < 0) begin
        diff = i; bad_got = out; bad_exp = fresh[i];
      end
    end
    checks++;
    if (diff >= 0) begin
      failures++;
      $display("FAIL resettle_traj cycle %0d got %0d expected %0d", diff, bad_got, bad_exp);
    end
  endtask

  task automatic test_random;
    int bad;
    logic [WIDTH-1:0] bad_got;
    logic [WIDTH-1:0] bad_exp;
    bad = -1;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
      if (out !== m_out && bad < 0) begin
        bad = i; bad_got = out; bad_exp = m_out;
      end
    end
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL random_traj cycle %0d got %0d expected %0d", bad, bad_got, bad_exp);
    end
  endtask

  // Scenario sequence.
  initial begin
    rst     = 1'b1;
    en      = 1'b0;
    in      = 1'b0;
    m_a1    = 0;
    m_a2    = 0;
    m_out   = '0;
    mod_acc = 0;
    test_reset();
    test_constant(1'b1, "const_one");
    test_constant(1'b0, "const_zero");
    test_idle();
    test_modulator(64, "mod_pos");
    test_modulator(-64, "mod_neg");
    test_modulator(0, "mod_zero");
    test_en_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sd_magnitude.md
# sd_magnitude

Recovers the magnitude envelope of a 1-bit sigma-delta bitstream. It sits after a sigma-delta modulator (e.g. a 2nd-order modulator at 2 bits growth) and beside a Sinc3 decimator. It produces an unsigned level proportional to |mean(x)|, where x is the signal encoded in the bitstream. The block is built from a signed leaky-integrator demodulator, a rectifier and an unsigned leaky-integrator smoother.

## Interface
- WIDTH, 16: output width; internal full scale FS = 2^(WIDTH-1)-1.
- GAIN, 6: leaky-integrator time-constant shift; time constant ≈ 2^GAIN enabled cycles.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en   in  1  clock enable; state updates only when high (allows slower sample rate).
- in   in  1  sigma-delta bit; 1 = +FS, 0 = −FS.
- out  out  WIDTH  unsigned magnitude estimate.

## Operation
- Bit decode: v = in ? +FS : −FS (signed, WIDTH+1 bits).
- Stage 1 (demodulator): signed register a1, WIDTH+GAIN+1 bits; e1 = a1 >>> GAIN (arithmetic). On each enabled edge, a1 <= a1 + v − e1. Steady state: e1 ≈ mean(v). |e1| ≤ FS always; no saturation logic is needed.
- Rectify: m = |e1| (unsigned, WIDTH−1 bits); scaled value s = m << 1 (range 0..2^WIDTH−2).
- Stage 2 (smoother): unsigned register a2, WIDTH+GAIN bits; out = a2 >> GAIN. On each enabled edge, a2 <= a2 + s − out. out never exceeds 2^WIDTH−2, so no wrap occurs.
- en low: a1, a2 and out hold their values; in is ignored.
- rst high: a1 = 0, a2 = 0, out = 0. rst has priority over en. Reset mid-stream restarts the settling from zero.

## Timing
- in is sampled on the enabled edge N and updates a1 at edge N.
- e1/m/s are combinational from a1, so the sample reaches a2 at the next enabled edge N+1. out is registered (a2 >> GAIN) and reflects it after edge N+1.
- Step response: first order per stage. out reaches 63% of final value in ≈ 2·2^GAIN enabled cycles and >99% within ≈ 12·2^GAIN cycles (≈768 for GAIN=6).
- Residual ripple on out for an idle pattern (1010…) is bounded by ≈ 2·FS/2^GAIN·2.
- No handshake; out is valid every cycle after the first enabled edge following reset.

## Configuration
- SD_MAGNITUDE_SMOOTH_EN defined: stage 2 is present as described.
- Not defined: stage 2 is removed. On each enabled edge, out <= s (registered), so latency is one enabled edge after a1 updates. Reset value stays 0, and the ripple equals the stage-1 ripple.

## Structure
- Shared package sd_pkg holds:
  - a function clog2;
  - a localparam helper for FS = 2^(WIDTH-1)-1;
  - the decode constants for bit 1/0 (+FS/−FS).
- One sub-module, sd_leaky_int, parameterised by DATA_WIDTH, GAIN and SIGNED.
  - Ports: clk, rst, en, din, dout.
  - Implements acc <= acc + din − (acc >> GAIN) and exposes dout = acc >> GAIN.
  - Instantiated for stage 1 (signed) and stage 2 (unsigned, only under SD_MAGNITUDE_SMOOTH_EN).
- The top level performs decode, rectify and output register.

## Test plan
- Reset: hold rst 3 cycles with in toggling -> out = 0 on every cycle during reset and on the first cycle after release.
- Constant in=1 for 2000 enabled cycles, WIDTH=16, GAIN=6 -> out ≥ 65000 and ≤ 65534. Constant in=0 -> the same range (rectified).
- Idle alternating 1010… for 2000 cycles -> out < 4096.
- Drive from a modulator with a signed 8-bit input of 64, then −64 -> out settles to ≈ 32767 ± 2048 for both signs. With input 0 -> out < 4096.
- en held low for 100 cycles mid-stream with in changing -> out is bit-identical throughout the hold. Resuming en continues from the held state.
- Assert rst mid-settling (out ≈ 30000) -> out = 0 at the next edge. Re-settling matches the fresh-start trajectory cycle for cycle.
